// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: deserialises PS/2 keyboard frames into scan codes, decoding the E0 (extended) and F0 (break) prefixes.
// Ports: clk, reset (sync, active-high); ps2_clk, ps2_data (raw asynchronous pins);
//   scan_code[7:0], is_break, is_ext (latched with each code_valid pulse);
//   code_valid, parity_err, frame_err (1-cycle pulses, mutually exclusive);
//   left_up, left_down, right_up, right_down (held-key levels, built only with PS2_KEY_STATE_EN).
// Macro PS2_KEY_STATE_EN: when defined, key levels follow make/break codes for W, S, Up and Down.
//   When it is undefined, the key levels are tied to 0.
module ps2_key_receiver #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 12500,
  parameter int TO_W = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       parity_err,
  output logic       frame_err,
  output logic       left_up,
  output logic       left_down,
  output logic       right_up,
  output logic       right_down
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic clk_f, clk_f_d;
  logic [FW-1:0] f_cnt;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n;
  logic par, par_n;
  logic [TO_W-1:0] to_cnt;
  logic ext_pend, brk_pend;
  logic bit_in, strobe, timeout, done, par_ok, byte_ok;
  assign bit_in = data_sync[1];
  assign strobe = clk_f_d & ~clk_f;
  // A strobe in the same cycle restarts the timer, so it wins over the timeout.
  assign timeout = state != IDLE && !strobe && to_cnt == TO_W'(TIMEOUT_CYCLES);
  assign done = strobe && state == STOP;
  assign par_ok = ^{sh, par};
  assign byte_ok = done && par_ok && bit_in;
  // The filtered clock only moves after FILTER_LEN consecutive synced samples that disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      clk_f <= 1'b1;
      clk_f_d <= 1'b1;
      f_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_f_d <= clk_f;
      if (clk_sync[1] == clk_f) f_cnt <= '0;
      else if (f_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_sync[1];
        f_cnt <= '0;
      end else f_cnt <= f_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      par <= par_n;
    end
  end
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    par_n = par;
    if (timeout) state_n = IDLE;
    else if (strobe)
      case (state)
        IDLE: if (!bit_in) begin
          state_n = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          sh_n = {bit_in, sh[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_n = bit_in;
          state_n = STOP;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      scan_code <= 8'h00;
      is_break <= 1'b0;
      is_ext <= 1'b0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      to_cnt <= (strobe || state == IDLE) ? '0 : to_cnt + 1'b1;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      if (timeout || (done && !byte_ok)) begin
        parity_err <= done && !par_ok;
        frame_err <= timeout || (done && par_ok);
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok && sh == 8'hE0) ext_pend <= 1'b1;
      else if (byte_ok && sh == 8'hF0) brk_pend <= 1'b1;
      else if (byte_ok) begin
        scan_code <= sh;
        is_ext <= ext_pend;
        is_break <= brk_pend;
        code_valid <= 1'b1;
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end
`ifdef PS2_KEY_STATE_EN
  logic code_ok;
  assign code_ok = byte_ok && sh != 8'hE0 && sh != 8'hF0;
  always_ff @(posedge clk) begin
    if (reset) begin
      left_up <= 1'b0;
      left_down <= 1'b0;
      right_up <= 1'b0;
      right_down <= 1'b0;
    end else if (code_ok) begin
      if (sh == 8'h1D && !ext_pend) left_up <= !brk_pend;
      if (sh == 8'h1B && !ext_pend) left_down <= !brk_pend;
      if (sh == 8'h75 && ext_pend) right_up <= !brk_pend;
      if (sh == 8'h72 && ext_pend) right_down <= !brk_pend;
    end
  end
`else
  assign left_up = 1'b0;
  assign left_down = 1'b0;
  assign right_up = 1'b0;
  assign right_down = 1'b0;
`endif
endmodule
